register_file_2r1w: RTL and testbench

Two-read / one-write register file for the processor datapath: 16 words of W bits, registered (1-cycle) read ports with valid flags, and address 15 mapped to the externally supplied PC+8 value instead of storage. It is the read-side counterpart to the single write-enable registers used elsewhere in the datapath. Decode reads operands here and writeback writes results here.

---
 rtl/processor_pkg.sv | 7 +
 rtl/register_file_2r1w_if.sv | 21 ++
 rtl/register_asynchronous_reset_write_en.sv | 14 +
 rtl/register_file_2r1w.sv | 47 ++++
 tb/tb_register_file_2r1w.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/processor_pkg.sv
// processor_pkg: shared register-file address and reset constants
package processor_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int REG_COUNT = 16;
  localparam logic [REG_ADDR_W-1:0] PC_ALIAS_ADDR = 4'd15;
  localparam int REG_RESET_VALUE = 0;
endpackage

// File: rtl/register_file_2r1w_if.sv
// register_file_2r1w_if: write port, r15_in and two read ports; master drives requests, slave returns registered read data/valid
interface register_file_2r1w_if import processor_pkg::*; #(parameter int W = 32);
  logic write_enable;
  logic [REG_ADDR_W-1:0] write_addr;
  logic [W-1:0] write_data;
  logic [W-1:0] r15_in;
  logic read_enable_a, read_enable_b;
  logic [REG_ADDR_W-1:0] read_addr_a, read_addr_b;
  logic [W-1:0] read_data_a, read_data_b;
  logic read_valid_a, read_valid_b;
  modport master(
    output write_enable, write_addr, write_data, r15_in,
    output read_enable_a, read_addr_a, read_enable_b, read_addr_b,
    input read_data_a, read_valid_a, read_data_b, read_valid_b
  );
  modport slave(
    input write_enable, write_addr, write_data, r15_in,
    input read_enable_a, read_addr_a, read_enable_b, read_addr_b,
    output read_data_a, read_valid_a, read_data_b, read_valid_b
  );
endinterface

// File: rtl/register_asynchronous_reset_write_en.sv
// register_asynchronous_reset_write_en: W-bit register, async active-high reset, load on write_enable; ports clk, reset_asynchronous, write_enable, inp_reg, out_reg
module register_asynchronous_reset_write_en import processor_pkg::*; #(
  parameter int W = 32
) (
  input  logic clk,
  input  logic reset_asynchronous,
  input  logic write_enable,
  input  logic [W-1:0] inp_reg,
  output logic [W-1:0] out_reg
);
  always_ff @(posedge clk or posedge reset_asynchronous)
    if (reset_asynchronous) out_reg <= W'(REG_RESET_VALUE);
    else if (write_enable) out_reg <= inp_reg;
endmodule

// File: rtl/register_file_2r1w.sv
// register_file_2r1w: 15-word 2R1W regfile with address 15 aliased to r15_in; ports clk, reset_asynchronous, rf (slave); macro REGFILE_WRITE_BYPASS_EN selects write-before-read on same-edge hazards
module register_file_2r1w import processor_pkg::*; #(
  parameter int W = 32,
  parameter int N = REG_COUNT
) (
  input logic clk,
  input logic reset_asynchronous,
  register_file_2r1w_if.slave rf
);
`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic [W-1:0] mem [N];
  logic [N-2:0] we;
  logic [W-1:0] val_a, val_b;
  for (genvar i = 0; i < N - 1; i++) begin : g_word
    assign we[i] = rf.write_enable && rf.write_addr == REG_ADDR_W'(i);
    register_asynchronous_reset_write_en #(.W(W)) u_reg (
      .clk(clk),
      .reset_asynchronous(reset_asynchronous),
      .write_enable(we[i]),
      .inp_reg(rf.write_data),
      .out_reg(mem[i])
    );
  end
  assign mem[N-1] = '0;
  always_comb begin
    val_a = rf.read_addr_a == PC_ALIAS_ADDR ? rf.r15_in :
            BYPASS && rf.write_enable && rf.write_addr == rf.read_addr_a ? rf.write_data : mem[rf.read_addr_a];
    val_b = rf.read_addr_b == PC_ALIAS_ADDR ? rf.r15_in :
            BYPASS && rf.write_enable && rf.write_addr == rf.read_addr_b ? rf.write_data : mem[rf.read_addr_b];
  end
  always_ff @(posedge clk or posedge reset_asynchronous)
    if (reset_asynchronous) begin
      rf.read_data_a <= '0;
      rf.read_data_b <= '0;
      rf.read_valid_a <= 1'b0;
      rf.read_valid_b <= 1'b0;
    end else begin
      rf.read_valid_a <= rf.read_enable_a;
      rf.read_valid_b <= rf.read_enable_b;
      if (rf.read_enable_a) rf.read_data_a <= val_a;
      if (rf.read_enable_b) rf.read_data_b <= val_b;
    end
endmodule

// File: tb/tb_register_file_2r1w.sv
// tb_register_file_2r1w: directed self-checking bench for register_file_2r1w
module tb_register_file_2r1w;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int compared = 0;
  int mismatched = 0;
  register_file_2r1w_if #(.W(32)) rf ();
  register_file_2r1w #(.W(32), .N(16)) dut (
    .clk(clk),
    .reset_asynchronous(rst),
    .rf(rf)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    rf.write_enable = 1'b0;
    rf.read_enable_a = 1'b0;
    rf.read_enable_b = 1'b0;
  endtask
  initial begin
    logic [31:0] hz;
`ifdef REGFILE_WRITE_BYPASS_EN
    hz = 32'h22;
`else
    hz = 32'h11;
`endif
    rf.write_enable = 1'b0;
    rf.write_addr = '0;
    rf.write_data = '0;
    rf.r15_in = 32'h108;
    rf.read_enable_a = 1'b0;
    rf.read_addr_a = '0;
    rf.read_enable_b = 1'b0;
    rf.read_addr_b = '0;
    #2 rst = 1'b1;
    #2;
    check("init_data_a", rf.read_data_a, 0);
    check("init_valid_b", {31'b0, rf.read_valid_b}, 0);
    #4 rst = 1'b0;
    rf.write_enable = 1'b1; rf.write_addr = 4'd3; rf.write_data = 32'hDEADBEEF;
    rf.read_enable_a = 1'b1; rf.read_addr_a = 4'd15;
    rf.read_enable_b = 1'b1; rf.read_addr_b = 4'd15;
    tick();
    check("pre_rst_data_a", rf.read_data_a, 32'h108);
    check("pre_rst_valid_a", {31'b0, rf.read_valid_a}, 1);
    rf.write_enable = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_data_a", rf.read_data_a, 0);
    check("rst_data_b", rf.read_data_b, 0);
    check("rst_valid_a", {31'b0, rf.read_valid_a}, 0);
    check("rst_valid_b", {31'b0, rf.read_valid_b}, 0);
    #1 rst = 1'b0;
    rf.read_addr_a = 4'd3; rf.read_enable_b = 1'b0;
    tick();
    check("r3_after_rst", rf.read_data_a, 0);
    check("r3_after_rst_valid", {31'b0, rf.read_valid_a}, 1);
    idle();
    rf.write_enable = 1'b1; rf.write_addr = 4'd5; rf.write_data = 32'h12345678;
    tick();
    idle();
    rf.read_enable_a = 1'b1; rf.read_addr_a = 4'd5;
    rf.read_enable_b = 1'b1; rf.read_addr_b = 4'd5;
    tick();
    check("r5_a", rf.read_data_a, 32'h12345678);
    check("r5_b", rf.read_data_b, 32'h12345678);
    check("r5_valid_a", {31'b0, rf.read_valid_a}, 1);
    check("r5_valid_b", {31'b0, rf.read_valid_b}, 1);
    idle();
    tick();
    check("pulse_end_a", {31'b0, rf.read_valid_a}, 0);
    check("pulse_end_b", {31'b0, rf.read_valid_b}, 0);
    check("hold_r5_a", rf.read_data_a, 32'h12345678);
    rf.write_enable = 1'b1; rf.write_addr = 4'd15; rf.write_data = 32'hFFFFFFFF;
    tick();
    idle();
    rf.read_enable_a = 1'b1; rf.read_addr_a = 4'd15;
    rf.read_enable_b = 1'b1; rf.read_addr_b = 4'd14;
    tick();
    check("pc_alias", rf.read_data_a, 32'h108);
    check("pc_r14_untouched", rf.read_data_b, 0);
    rf.r15_in = 32'h10C; rf.read_addr_b = 4'd5;
    tick();
    check("pc_alias_new", rf.read_data_a, 32'h10C);
    check("pc_r5_untouched", rf.read_data_b, 32'h12345678);
    idle();
    rf.write_enable = 1'b1; rf.write_addr = 4'd7; rf.write_data = 32'h11;
    tick();
    rf.write_data = 32'h22;
    rf.read_enable_a = 1'b1; rf.read_addr_a = 4'd7;
    rf.read_enable_b = 1'b1; rf.read_addr_b = 4'd7;
    tick();
    check("hazard_a", rf.read_data_a, hz);
    check("hazard_b", rf.read_data_b, hz);
    rf.write_enable = 1'b0;
    tick();
    check("hazard_next", rf.read_data_a, 32'h22);
    idle();
    rf.write_enable = 1'b1; rf.write_addr = 4'd2; rf.write_data = 32'hA5;
    tick();
    rf.write_enable = 1'b0;
    rf.read_enable_a = 1'b1; rf.read_addr_a = 4'd2;
    tick();
    check("hold_read", rf.read_data_a, 32'hA5);
    rf.read_enable_a = 1'b0;
    rf.write_enable = 1'b1; rf.write_data = 32'h5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_data", rf.read_data_a, 32'hA5);
      check("hold_valid", {31'b0, rf.read_valid_a}, 0);
    end
    rf.write_enable = 1'b0;
    rf.read_enable_a = 1'b1;
    tick();
    check("hold_new", rf.read_data_a, 32'h5A);
    idle();
    for (int i = 0; i < 15; i++) begin
      rf.write_enable = 1'b1; rf.write_addr = 4'(i); rf.write_data = i * 32'h01010101;
      tick();
    end
    rf.write_enable = 1'b0;
    rf.read_enable_a = 1'b1;
    rf.read_enable_b = 1'b1;
    for (int i = 0; i < 15; i++) begin
      rf.read_addr_a = 4'(i);
      rf.read_addr_b = 4'(14 - i);
      tick();
      check("sweep_a", rf.read_data_a, i * 32'h01010101);
      check("sweep_b", rf.read_data_b, (14 - i) * 32'h01010101);
      check("sweep_valid", {30'b0, rf.read_valid_a, rf.read_valid_b}, 3);
    end
    idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
